// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg
//   Shared definitions for the interrupt controller: dispatch FSM state type,
//   named source indices, default register addresses and vector base.
//   Optional feature macro used by interrupt_ctrl: INTC_EDGE_DETECT_EN.
// -----------------------------------------------------------------------------
package intc_pkg;

    // Dispatch handshake states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } intc_state_e;

    // Grant index width; supports up to 8 sources.
    localparam int IDX_W = 3;

    // Source indices, 0 is the highest priority.
    localparam int SRC_VBLANK  = 0;
    localparam int SRC_LCDSTAT = 1;
    localparam int SRC_TIMER   = 2;
    localparam int SRC_SERIAL  = 3;
    localparam int SRC_JOYPAD  = 4;

    // Default CPU register addresses and vector of source 0.
    localparam logic [15:0] DEF_IF_ADDR  = 16'hFF0F;
    localparam logic [15:0] DEF_IE_ADDR  = 16'hFFFF;
    localparam logic [15:0] DEF_VEC_BASE = 16'h0040;

endpackage

// File: rtl/intc_prio_enc.sv
// -----------------------------------------------------------------------------
// intc_prio_enc
//   Lowest-set-bit priority encoder for the pending interrupt vector.
//   Ports:
//     req    in   NUM_SRC  pending request bits (bit 0 = highest priority)
//     idx    out  IDX_W    index of the lowest set bit (0 when none set)
//     valid  out  1        at least one request bit is set
// -----------------------------------------------------------------------------
import intc_pkg::*;

module intc_prio_enc #(
    parameter int NUM_SRC = 5
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Scan upward and keep the first hit so bit 0 wins.
    always_comb begin
        idx   = {IDX_W{1'b0}};
        valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!valid && req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end else begin
                idx   = idx;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl
//   Interrupt controller between the peripherals and the CPU. Owns IF/IE,
//   latches source events, grants the lowest-index pending source and runs a
//   request/acknowledge dispatch handshake. Also drives the HALT wake line.
//   Ports:
//     I_CLOCK / I_RESET         clock, synchronous active-high reset
//     I_IRQ                     source event lines
//     I_CPU_ADDR/I_CPU_DATA     CPU bus, I_MEM_WE_L active-low write strobe
//     O_CPU_DATA/O_CPU_DATA_OE  IF/IE read data and address-hit flag
//     I_IME                     CPU master interrupt enable
//     O_INT_REQ/O_INT_VECTOR    dispatch request and frozen vector
//     I_INT_ACK                 CPU accepts the request
//     O_SRC_ACK                 one-cycle pulse to the serviced source
//     O_WAKE                    |(IF & IE), ignores I_IME
//   Build option INTC_EDGE_DETECT_EN: I_IRQ are levels and only a 0->1
//   transition sets IF. Without it every high cycle of I_IRQ sets IF.
// -----------------------------------------------------------------------------
import intc_pkg::*;

module interrupt_ctrl #(
    parameter int          NUM_SRC    = 5,
    parameter logic [15:0] IF_ADDR    = DEF_IF_ADDR,
    parameter logic [15:0] IE_ADDR    = DEF_IE_ADDR,
    parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
    parameter int          VEC_STRIDE = 8
) (
    input  logic               I_CLOCK,
    input  logic               I_RESET,
    input  logic [NUM_SRC-1:0] I_IRQ,
    input  logic [15:0]        I_CPU_ADDR,
    input  logic [7:0]         I_CPU_DATA,
    input  logic               I_MEM_WE_L,
    output logic [7:0]         O_CPU_DATA,
    output logic               O_CPU_DATA_OE,
    input  logic               I_IME,
    output logic               O_INT_REQ,
    output logic [15:0]        O_INT_VECTOR,
    input  logic               I_INT_ACK,
    output logic [NUM_SRC-1:0] O_SRC_ACK,
    output logic               O_WAKE
);

    logic [NUM_SRC-1:0] if_r, ie_r, if_nxt_s, event_s, pend_s, ack_mask_s;
    logic [NUM_SRC-1:0] src_ack_r;
    logic [IDX_W-1:0]   grant_idx_s, idx_r;
    logic               grant_vld_s, ack_fire_s, req_r;
    logic               we_if_s, we_ie_s;
    logic [15:0]        vec_calc_s, vec_r;
    logic [7:0]         rd_data_s;
    logic               rd_oe_s;
    intc_state_e        state_r, state_nxt_s;
    logic               unused_data_s;

    // Upper write-data bits beyond NUM_SRC carry no state.
    assign unused_data_s = ^I_CPU_DATA;

`ifdef INTC_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] irq_prev_r;

    // Previous line sample; all-ones at reset so lines already high are not events.
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            irq_prev_r <= {NUM_SRC{1'b1}};
        end else begin
            irq_prev_r <= I_IRQ;
        end
    end

    assign event_s = I_IRQ & ~irq_prev_r;
`else
    assign event_s = I_IRQ;
`endif

    assign we_if_s = !I_MEM_WE_L && (I_CPU_ADDR == IF_ADDR);
    assign we_ie_s = !I_MEM_WE_L && (I_CPU_ADDR == IE_ADDR);
    assign pend_s  = if_r & ie_r;

    intc_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .req   (pend_s),
        .idx   (grant_idx_s),
        .valid (grant_vld_s)
    );

    assign vec_calc_s = VEC_BASE + (16'(grant_idx_s) * 16'(VEC_STRIDE));

    // One-hot mask of the currently dispatched source.
    always_comb begin
        ack_mask_s = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_mask_s[i] = (idx_r == IDX_W'(i));
        end
    end

    // IF next value: ack clears, CPU write replaces, new events always win.
    always_comb begin
        if_nxt_s = if_r;
        if (ack_fire_s) begin
            if_nxt_s = if_r & ~ack_mask_s;
        end else begin
            if_nxt_s = if_r;
        end
        if (we_if_s) begin
            if_nxt_s = I_CPU_DATA[NUM_SRC-1:0];
        end else begin
            if_nxt_s = if_nxt_s;
        end
        if_nxt_s = if_nxt_s | event_s;
    end

    // IF / IE register storage.
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            if_r <= {NUM_SRC{1'b0}};
            ie_r <= {NUM_SRC{1'b0}};
        end else begin
            if_r <= if_nxt_s;
            if (we_ie_s) begin
                ie_r <= I_CPU_DATA[NUM_SRC-1:0];
            end else begin
                ie_r <= ie_r;
            end
        end
    end

    // Register read mux; unimplemented upper bits read as 1.
    always_comb begin
        rd_data_s = 8'hFF;
        rd_oe_s   = 1'b0;
        if (I_CPU_ADDR == IF_ADDR) begin
            rd_data_s[NUM_SRC-1:0] = if_r;
            rd_oe_s                = 1'b1;
        end else if (I_CPU_ADDR == IE_ADDR) begin
            rd_data_s[NUM_SRC-1:0] = ie_r;
            rd_oe_s                = 1'b1;
        end else begin
            rd_data_s = 8'hFF;
            rd_oe_s   = 1'b0;
        end
    end

    // Dispatch FSM next state; ack takes precedence over an IME drop.
    always_comb begin
        state_nxt_s = state_r;
        ack_fire_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (I_IME && grant_vld_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (I_INT_ACK) begin
                    ack_fire_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (!I_IME) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, frozen grant and registered handshake outputs.
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            state_r   <= ST_IDLE;
            req_r     <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            vec_r     <= VEC_BASE;
            src_ack_r <= {NUM_SRC{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            req_r     <= (state_nxt_s == ST_REQ);
            src_ack_r <= ack_fire_s ? ack_mask_s : {NUM_SRC{1'b0}};
            if ((state_r == ST_IDLE) && (state_nxt_s == ST_REQ)) begin
                idx_r <= grant_idx_s;
                vec_r <= vec_calc_s;
            end else begin
                idx_r <= idx_r;
                vec_r <= vec_r;
            end
        end
    end

    assign O_CPU_DATA    = rd_data_s;
    assign O_CPU_DATA_OE = rd_oe_s;
    assign O_INT_REQ     = req_r;
    assign O_INT_VECTOR  = vec_r;
    assign O_SRC_ACK     = src_ack_r;
    assign O_WAKE        = |pend_s;

endmodule
